reglist_sequencer: RTL
======================

// Module: reglist_sequencer
// PURPOSE
//  Sequences multi-register transfers (PUSH/POP, LDM/STM) after decode. Takes the
//  register list and base (SP) value and issues one register<->memory word transfer
//  per accepted memory cycle. Holds stall high so fetch/decode freeze. Finishes with
//  one base-register writeback.
// PARAMETERS
//  ADDR_W      32  address / base register width
//  WORD_BYTES  4   address increment per transfer
//  LIST_W      8   low register-list width (r0..r7)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  start        in   1       decode has a multi-register op; sampled only in IDLE
//  is_load      in   1       1 = POP/LDM (mem->reg), 0 = PUSH/STM (reg->mem)
//  r_list       in   LIST_W  low register list from decode
//  r_extra      in   1       list bit 8: LR for store, PC for load (REGLIST_LRPC_EN only)
//  base         in   ADDR_W  base value (SP) at start
//  mem_ready    in   1       memory accepts/completes current transfer this cycle
//  mem_addr     out  ADDR_W  word address of current transfer
//  mem_re       out  1       read strobe (load)
//  mem_we       out  1       write strobe (store)
//  reg_idx      out  4       register index for current transfer (0..7, 14, 15)
//  base_we      out  1       one-cycle pulse: write base_new to base register
//  base_new     out  ADDR_W  updated base value
//  pc_load      out  1       one-cycle pulse with base_we when PC was loaded
//  stall        out  1       freeze fetch/decode
//  done         out  1       one-cycle completion pulse
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; pending list cleared.
//  - FSM IDLE -> XFER -> WB -> IDLE.
//  - IDLE: start=1 latches list, is_load and base; cnt = popcount(list).
//    Start address: store = base - WORD_BYTES*cnt; load = base.
//    Go to XFER; go to WB if list empty.
//  - XFER: reg_idx = lowest set bit of pending list (ascending order); mem_re/mem_we
//    asserted. On mem_ready: clear that bit, mem_addr += WORD_BYTES.
//    When the last bit clears, go to WB.
//  - mem_ready=0: mem_addr, reg_idx and strobes hold stable. No timeout.
//  - WB: base_we=1. base_new = base - 4*cnt (store) or base + 4*cnt (load).
//    done=1. Next state IDLE.
//  - Empty list: no strobes; WB the cycle after start; base_new = base; done pulses.
//  - Latency: 1 + N_accepted_cycles + 1 cycles from start to done.
//  - stall = start_in_IDLE | (state != IDLE); combinational, so it rises in the
//    same cycle as start.
//  - Inputs are ignored while busy. Only one transfer is outstanding; no pipelining.
//  - Reset mid-op: IDLE next edge. Strobes drop immediately at that edge. No base_we.
//    Partial memory effects stand.
//  - Widths: popcount is 4 bits. Offset = cnt << log2(WORD_BYTES). Address math wraps
//    modulo 2^ADDR_W.
// CONFIGURATION
//  REGLIST_LRPC_EN defined:
//    - r_extra is appended as list bit 8, ordered last.
//    - Its register is 14 (LR) on store and 15 (PC) on load; it is counted in cnt.
//    - A load with r_extra asserts pc_load with base_we.
//  REGLIST_LRPC_EN undefined:
//    - r_extra is ignored; cnt is at most 8.
//    - pc_load is tied 0.
//    - reg_idx never exceeds 7.
// STRUCTURE
//  - reglist_pkg: FSM state encoding (IDLE/XFER/WB); LR_IDX=14, PC_IDX=15;
//    WORD_SHIFT=log2(WORD_BYTES); popcount function.
//  - Sub-module reglist_prio_enc: combinational lowest-set-bit encoder with a
//    valid output. It is instantiated once over the 9-bit pending list.
// TESTING
//  1. PUSH {r7,lr}: list=0x80, r_extra=1, base=0x1000, mem_ready=1 (LRPC_EN)
//     -> we @0x0FF8 r7, then @0x0FFC r14; base_new=0x0FF8; done at cycle 4.
//  2. POP {r7,pc}: list=0x80, r_extra=1, base=0x0FF8, load
//     -> re @0x0FF8 r7, then @0x0FFC r15; base_new=0x1000; pc_load=1 with base_we.
//  3. STM list=0x0B, base=0x2000, mem_ready low 3 cycles on second transfer
//     -> r0@0x1FF4, r1@0x1FF8 held stable 4 cycles, r3@0x1FFC; stall high throughout.
//  4. Empty list, base=0x3000
//     -> no strobes; base_we and done at cycle 2; base_new=0x3000.
//  5. Reset asserted during second XFER cycle of list=0xFF
//     -> next cycle all outputs 0, state IDLE, no base_we. A new start works normally.
//  6. start pulsed again while busy with list=0x03
//     -> ignored; only the original transfers occur.
//  Build without REGLIST_LRPC_EN: rerun test 1 -> only r7 @0x0FFC; base_new=0x0FFC.

Source files
------------

// File: rtl/reglist_pkg.sv
// Shared types and constants for the multi-register transfer sequencer:
// FSM encoding, LR/PC register indices and the register-list popcount.
package reglist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [3:0] LR_IDX      = 4'd14;
  localparam logic [3:0] PC_IDX      = 4'd15;
  localparam int         WORD_BYTES  = 4;
  localparam int         WORD_SHIFT  = $clog2(WORD_BYTES);
  localparam int         LIST_FULL_W = 9;

  function automatic logic [3:0] popcount(input logic [LIST_FULL_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < LIST_FULL_W; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/reglist_prio_enc.sv
// Lowest-set-bit encoder over the pending register list; valid is low when
// the list is empty.
module reglist_prio_enc #(
  parameter int W = 9
) (
  input  logic [W-1:0] vec,
  output logic [3:0]   idx,
  output logic         valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reglist_sequencer.sv
// PUSH/POP/LDM/STM sequencer: one word transfer per accepted memory cycle,
// then a base writeback. Define REGLIST_LRPC_EN to enable list bit 8 (LR/PC).
module reglist_sequencer
  import reglist_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int LIST_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [LIST_W-1:0] r_list,
  input  logic              r_extra,
  input  logic [ADDR_W-1:0] base,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        reg_idx,
  output logic              base_we,
  output logic [ADDR_W-1:0] base_new,
  output logic              pc_load,
  output logic              stall,
  output logic              done
);

  localparam int PL_W  = LIST_W + 1;
  localparam int SHIFT = $clog2(WORD_BYTES);

  state_t            state, state_next;
  logic [PL_W-1:0]   list_in, pend, pend_cleared;
  logic [3:0]        cnt_in, cnt_q, enc_idx;
  logic [ADDR_W-1:0] base_q, addr_q, off_in, off_q;
  logic              is_load_q, enc_valid, start_ok, xfer_on, accept;

`ifdef REGLIST_LRPC_EN
  assign list_in = {r_extra, r_list};
`else
  logic unused_r_extra;
  assign list_in        = {1'b0, r_list};
  assign unused_r_extra = r_extra;
`endif

  assign cnt_in       = popcount(list_in);
  assign off_in       = ADDR_W'(cnt_in) << SHIFT;
  assign off_q        = ADDR_W'(cnt_q) << SHIFT;
  assign start_ok     = (state == ST_IDLE) && start;
  assign xfer_on      = (state == ST_XFER) && enc_valid;
  assign accept       = xfer_on && mem_ready;
  assign pend_cleared = pend & (pend - PL_W'(1));

  reglist_prio_enc #(.W(PL_W)) u_enc (
    .vec   (pend),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = (cnt_in == 4'd0) ? ST_WB : ST_XFER;
      ST_XFER: if (!enc_valid || (accept && pend_cleared == '0)) state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      is_load_q <= 1'b0;
      base_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
    end else if (start_ok) begin
      pend      <= list_in;
      is_load_q <= is_load;
      base_q    <= base;
      cnt_q     <= cnt_in;
      // Stores pre-decrement so the block lands just below the old base.
      addr_q    <= is_load ? base : base - off_in;
    end else if (accept) begin
      pend      <= pend_cleared;
      addr_q    <= addr_q + ADDR_W'(WORD_BYTES);
    end
  end

  assign mem_addr = xfer_on ? addr_q : '0;
  assign mem_re   = xfer_on && is_load_q;
  assign mem_we   = xfer_on && !is_load_q;
  assign reg_idx  = !xfer_on ? 4'd0 :
                    (enc_idx == 4'(LIST_W)) ? (is_load_q ? PC_IDX : LR_IDX) : enc_idx;
  assign base_we  = (state == ST_WB);
  assign done     = (state == ST_WB);
  assign base_new = (state != ST_WB) ? '0 :
                    is_load_q ? base_q + off_q : base_q - off_q;
  assign stall    = start_ok || (state != ST_IDLE);

`ifdef REGLIST_LRPC_EN
  logic extra_q;

  always_ff @(posedge clk) begin
    if (reset)         extra_q <= 1'b0;
    else if (start_ok) extra_q <= list_in[LIST_W];
  end

  assign pc_load = (state == ST_WB) && is_load_q && extra_q;
`else
  assign pc_load = 1'b0;
`endif

endmodule
